// File: rtl/led_trace_player_pkg.sv
// Shared types for the LED trace player: FSM state, buffered trace entry
// and the default display hold time.
package led_trace_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW,
        GAP
    } state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [7:0] data;
    } trace_entry_t;

    localparam int HOLD_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/led_trace_player_if.sv
// Write-back tap and LED/status bundle between the pipeline side (master)
// and the trace player (slave).
interface led_trace_player_if;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic [1:0]  i_byte_sel;
    logic [7:0]  o_led;
    logic [4:0]  o_led_rd;
    logic        o_showing;
    logic        o_empty;
    logic        o_full;
    logic        o_overflow;

    modport master (
        output i_wb_valid, i_wb_rd, i_wb_data, i_byte_sel,
        input  o_led, o_led_rd, o_showing, o_empty, o_full, o_overflow
    );

    modport slave (
        input  i_wb_valid, i_wb_rd, i_wb_data, i_byte_sel,
        output o_led, o_led_rd, o_showing, o_empty, o_full, o_overflow
    );
endinterface

// File: rtl/led_trace_player_fifo.sv
// Circular trace buffer with registered count, full/empty and sticky drop flag.
// Latency: push visible in count/empty on the next edge; read data is combinational at rdPtr.
// Backpressure: none upstream; a push while full is dropped and sets overflow.
module trace_fifo
    import led_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  trace_entry_t pushEntry,
    input  logic         pop,
    output trace_entry_t popEntry,
    output logic         empty,
    output logic         full,
    output logic         overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    trace_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W:0]     count;
    logic               doPush;
    logic               doPop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign popEntry = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/led_trace_player.sv
// Replays captured write-back bytes on the LEDs: LOAD, SHOW for HOLD_CYCLES, then GAP_CYCLES blank.
// Latency: push at edge n -> LOAD after n+1 -> LED valid after n+2; one entry per 1+HOLD+GAP cycles.
// Backpressure: none; drops pushes when full. Macro LED_TRACE_SKIP_X0_EN ignores writes to x0.
module led_trace_player
    import led_trace_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int GAP_CYCLES  = 1
) (
    input  logic               clk,
    input  logic               reset,
    led_trace_player_if.slave  bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + GAP_CYCLES + 1) + 1;

    state_t             state;
    state_t             nextState;
    logic [CNT_W-1:0]   phaseCnt;
    trace_entry_t       pushEntry;
    trace_entry_t       popEntry;
    trace_entry_t       dispEntry;
    logic               pushEn;
    logic               pop;
    logic               holdDone;
    logic               gapDone;

`ifdef LED_TRACE_SKIP_X0_EN
    assign pushEn = bus.i_wb_valid && (bus.i_wb_rd != 5'd0);
`else
    assign pushEn = bus.i_wb_valid;
`endif

    assign pushEntry.rd   = bus.i_wb_rd;
    assign pushEntry.data = bus.i_wb_data[{bus.i_byte_sel, 3'b000} +: 8];

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pushEn),
        .pushEntry (pushEntry),
        .pop       (pop),
        .popEntry  (popEntry),
        .empty     (bus.o_empty),
        .full      (bus.o_full),
        .overflow  (bus.o_overflow)
    );

    assign holdDone = (phaseCnt == CNT_W'(HOLD_CYCLES - 1));
    assign gapDone  = (phaseCnt == CNT_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (!bus.o_empty) nextState = LOAD;
            LOAD: nextState = SHOW;
            SHOW: begin
                if (holdDone) begin
                    if (GAP_CYCLES > 0)    nextState = GAP;
                    else if (!bus.o_empty) nextState = LOAD;
                    else                   nextState = IDLE;
                end
            end
            GAP:  if (gapDone) nextState = bus.o_empty ? IDLE : LOAD;
            default: nextState = IDLE;
        endcase
    end

    // Phase counter restarts on every state change, so each SHOW/GAP counts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phaseCnt  <= '0;
            dispEntry <= '0;
        end else begin
            if (state != nextState) begin
                phaseCnt <= '0;
            end else if (state == SHOW || state == GAP) begin
                phaseCnt <= phaseCnt + 1'b1;
            end
            if (state == LOAD) begin
                dispEntry <= popEntry;
            end
        end
    end

    always_comb begin
        pop           = 1'b0;
        bus.o_led     = '0;
        bus.o_led_rd  = '0;
        bus.o_showing = 1'b0;
        case (state)
            LOAD: pop = 1'b1;
            SHOW: begin
                bus.o_led     = dispEntry.data;
                bus.o_led_rd  = dispEntry.rd;
                bus.o_showing = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_led_trace_player.sv
// Directed bench for led_trace_player: vector table on a default instance plus
// sequences for overflow (long hold), wrap/no-gap concurrency and async reset.
module tb_led_trace_player;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_trace_player_if busA ();
    led_trace_player_if busB ();
    led_trace_player_if busC ();

    led_trace_player #(.DEPTH(8), .HOLD_CYCLES(4),  .GAP_CYCLES(1)) dutA (.clk(clk), .reset(reset), .bus(busA));
    led_trace_player #(.DEPTH(8), .HOLD_CYCLES(20), .GAP_CYCLES(1)) dutB (.clk(clk), .reset(reset), .bus(busB));
    led_trace_player #(.DEPTH(8), .HOLD_CYCLES(2),  .GAP_CYCLES(0)) dutC (.clk(clk), .reset(reset), .bus(busC));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        vld;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  bsel;
        logic [16:0] exp;   // {led, ledRd, showing, empty, full, overflow}
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] seenA[$];
    logic [12:0] seenB[$];
    logic [12:0] seenC[$];
    logic [12:0] expQ[$];
    logic        prevA = 1'b0;
    logic        prevB = 1'b0;
    logic        prevC = 1'b0;

    // Record {rd, byte} each time a SHOW period begins.
    always @(negedge clk) begin
        if (busA.o_showing && !prevA) seenA.push_back({busA.o_led_rd, busA.o_led});
        if (busB.o_showing && !prevB) seenB.push_back({busB.o_led_rd, busB.o_led});
        if (busC.o_showing && !prevC) seenC.push_back({busC.o_led_rd, busC.o_led});
        prevA <= busA.o_showing;
        prevB <= busB.o_showing;
        prevC <= busC.o_showing;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [16:0] statA();
        return {busA.o_led, busA.o_led_rd, busA.o_showing, busA.o_empty, busA.o_full, busA.o_overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveA(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [1:0] s);
        busA.i_wb_valid = v; busA.i_wb_rd = rd; busA.i_wb_data = d; busA.i_byte_sel = s;
    endtask

    task automatic driveB(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [1:0] s);
        busB.i_wb_valid = v; busB.i_wb_rd = rd; busB.i_wb_data = d; busB.i_byte_sel = s;
    endtask

    task automatic driveC(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [1:0] s);
        busC.i_wb_valid = v; busC.i_wb_rd = rd; busC.i_wb_data = d; busC.i_byte_sel = s;
    endtask

    function automatic vec_t mk(input logic vld, input logic [4:0] rd, input logic [31:0] data,
                                input logic [1:0] bsel, input logic [16:0] exp);
        vec_t v;
        v.vld = vld; v.rd = rd; v.data = data; v.bsel = bsel; v.exp = exp;
        return v;
    endfunction

    // One push from an idle, empty player: IDLE, LOAD, 4x SHOW, GAP, IDLE.
    task automatic addSeq(input logic [4:0] rd, input logic [31:0] data, input logic [1:0] bsel, input logic [7:0] b);
        vecs.push_back(mk(1'b1, rd, data, bsel, {8'h00, 5'd0, 4'b0000}));
        vecs.push_back(mk(1'b0, 5'd0, 32'd0, 2'd0, {8'h00, 5'd0, 4'b0000}));
        repeat (4) vecs.push_back(mk(1'b0, 5'd0, 32'd0, 2'd0, {b, rd, 4'b1100}));
        repeat (2) vecs.push_back(mk(1'b0, 5'd0, 32'd0, 2'd0, {8'h00, 5'd0, 4'b0100}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        driveA(1'b0, 5'd0, 32'd0, 2'd0);
        driveB(1'b0, 5'd0, 32'd0, 2'd0);
        driveC(1'b0, 5'd0, 32'd0, 2'd0);
        addSeq(5'd5,  32'h1234_56AB, 2'd0, 8'hAB);
        addSeq(5'd31, 32'hA1B2_C3D4, 2'd2, 8'hB2);
        addSeq(5'd9,  32'hA1B2_C3D4, 2'd1, 8'hC3);
        addSeq(5'd17, 32'hA1B2_C3D4, 2'd3, 8'hA1);

        repeat (3) tick();
        check("reset_held", 32'(statA()), 32'({8'h00, 5'd0, 4'b0100}));
        reset = 1'b1;

        // Reset state, nothing pushed
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle%0d", i), 32'(statA()), 32'({8'h00, 5'd0, 4'b0100}));
        end
        check("idleB_empty", 32'(busB.o_empty), 32'd1);
        check("idleC_show", 32'(busC.o_showing), 32'd0);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            driveA(vecs[i].vld, vecs[i].rd, vecs[i].data, vecs[i].bsel);
            tick();
            check($sformatf("vec%0d", i), 32'(statA()), 32'(vecs[i].exp));
        end
        driveA(1'b0, 5'd0, 32'd0, 2'd0);

        // Write to x0 followed by a write to x3
        seenA.delete();
        expQ.delete();
`ifndef LED_TRACE_SKIP_X0_EN
        expQ.push_back({5'd0, 8'hFF});
`endif
        expQ.push_back({5'd3, 8'h33});
        driveA(1'b1, 5'd0, 32'h0000_00FF, 2'd0); tick();
        driveA(1'b1, 5'd3, 32'h0000_0033, 2'd0); tick();
        driveA(1'b0, 5'd0, 32'd0, 2'd0);
        repeat (30) tick();
        check("x0_count", 32'(seenA.size()), 32'(expQ.size()));
        for (int i = 0; i < seenA.size() && i < expQ.size(); i++)
            check($sformatf("x0_entry%0d", i), 32'(seenA[i]), 32'(expQ[i]));
        check("x0_ovf", 32'(busA.o_overflow), 32'd0);

        // Overflow: fill while a long SHOW keeps the reader busy
        seenB.delete();
        driveB(1'b1, 5'd1, 32'h0000_00EE, 2'd0); tick();
        driveB(1'b0, 5'd0, 32'd0, 2'd0);
        begin
            int n = 0;
            while (!busB.o_showing && n < 10) begin tick(); n++; end
        end
        check("ovf_primer_show", 32'(busB.o_showing), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            driveB(1'b1, 5'(k), 32'(k), 2'd0);
            tick();
            if (k == 7) check("ovf_full7", 32'(busB.o_full), 32'd0);
            if (k == 8) begin
                check("ovf_full8", 32'(busB.o_full), 32'd1);
                check("ovf_flag8", 32'(busB.o_overflow), 32'd0);
            end
            if (k == 9) check("ovf_flag9", 32'(busB.o_overflow), 32'd1);
        end
        driveB(1'b0, 5'd0, 32'd0, 2'd0);
        check("ovf_full_end", 32'(busB.o_full), 32'd1);
        repeat (260) tick();
        check("ovf_count", 32'(seenB.size()), 32'd9);
        if (seenB.size() > 0) check("ovf_primer", 32'(seenB[0]), 32'({5'd1, 8'hEE}));
        for (int k = 1; k <= 8 && k < seenB.size(); k++)
            check($sformatf("ovf_entry%0d", k), 32'(seenB[k]), 32'({5'(k), 8'(k)}));
        check("ovf_sticky", 32'(busB.o_overflow), 32'd1);
        check("ovf_drained", 32'(busB.o_empty), 32'd1);

        // Wrap with concurrent push/pop, no gap
        seenC.delete();
        for (int j = 0; j < 20; j++) begin
            driveC(1'b1, 5'(j + 1), 32'h4030_2010 + 32'(j) * 32'h0101_0101, 2'(j % 4));
            tick();
            driveC(1'b0, 5'd0, 32'd0, 2'd0);
            if (j >= 2) repeat (2) tick();
        end
        repeat (20) tick();
        check("wrap_count", 32'(seenC.size()), 32'd20);
        for (int j = 0; j < 20 && j < seenC.size(); j++)
            check($sformatf("wrap_entry%0d", j), 32'(seenC[j]), 32'({5'(j + 1), 8'(16 * ((j % 4) + 1) + j)}));
        check("wrap_ovf", 32'(busC.o_overflow), 32'd0);
        check("wrap_empty", 32'(busC.o_empty), 32'd1);

        // Async reset while showing 0x55 with three entries behind it
        driveA(1'b1, 5'd7,  32'h0000_0055, 2'd0); tick();
        driveA(1'b1, 5'd8,  32'h0000_0066, 2'd0); tick();
        driveA(1'b1, 5'd9,  32'h0000_0077, 2'd0); tick();
        driveA(1'b1, 5'd10, 32'h0000_0088, 2'd0); tick();
        driveA(1'b0, 5'd0, 32'd0, 2'd0);
        check("rst_pre_show", 32'(statA()), 32'({8'h55, 5'd7, 4'b1000}));
        reset = 1'b0;
        #1;
        check("rst_async", 32'(statA()), 32'({8'h00, 5'd0, 4'b0100}));
        tick();
        reset = 1'b1;
        seenA.delete();
        repeat (30) tick();
        check("rst_no_replay", 32'(seenA.size()), 32'd0);
        check("rst_idle", 32'(statA()), 32'({8'h00, 5'd0, 4'b0100}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_trace_player.md
# led_trace_player

Read-side counterpart of the write-back LED trace. It captures register-file write-back events (Rd, data) from the MEM/WB stage into a small circular buffer. A reader FSM then pops each entry and shows one byte of it on the 8 board LEDs for a programmable number of cycles, followed by a blanking gap. It sits beside the pipeline top, taps the write-back bus, and owns the LED pins.

## Interface
Parameters:
- DEPTH, 8: buffer entries; power of two, 2..64.
- HOLD_CYCLES, 4: cycles each entry is shown; ≥1.
- GAP_CYCLES, 1: blank cycles after each entry; 0 disables the gap.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_wb_valid  in  1  write-back strobe (MEM/WB RegWrite).
- i_wb_rd  in  5  destination register of the write-back.
- i_wb_data  in  32  write-back value.
- i_byte_sel  in  2  byte of i_wb_data to record, sampled at push.
- o_led  out  8  displayed byte; 0 when not showing.
- o_led_rd  out  5  Rd of the displayed entry; 0 when not showing.
- o_showing  out  1  high while in SHOW.
- o_empty  out  1  buffer count == 0.
- o_full  out  1  buffer count == DEPTH.
- o_overflow  out  1  sticky; set when a push is dropped.

## Operation
- Push: an enabled push (i_wb_valid=1, subject to Configuration) stores {i_wb_rd, selected byte} at wr_ptr, then increments wr_ptr and count. Selected byte is i_wb_data[8*i_byte_sel +: 8].
- Full: the full test uses the registered count at the start of the cycle. An enabled push while count==DEPTH is dropped, even if a pop occurs in the same cycle. The drop sets o_overflow; pointers are unchanged.
- Pop: occurs only in LOAD. It reads the entry at rd_ptr, then increments rd_ptr and decrements count.
- Simultaneous push and pop with count<DEPTH: both take effect and count is unchanged.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. count is log2(DEPTH)+1 bits.
- FSM states:
  - IDLE: go to LOAD when !o_empty, else stay in IDLE.
  - LOAD: 1 cycle; pop the entry; latch byte and Rd into the display registers; go to SHOW.
  - SHOW: o_led and o_led_rd driven from the display registers; hold counter runs HOLD_CYCLES cycles. On expiry go to GAP if GAP_CYCLES>0. Otherwise go to LOAD if !o_empty, else IDLE.
  - GAP: o_led=0 and o_led_rd=0 for GAP_CYCLES cycles, then go to LOAD if !o_empty, else IDLE.
- o_overflow clears only on reset.

## Timing
- Reset values: state=IDLE, pointers=0, count=0, o_led=0, o_led_rd=0, o_showing=0, o_empty=1, o_full=0, o_overflow=0.
- Reset asserted mid-SHOW: everything returns to reset values immediately. Buffered entries are discarded.
- o_empty, o_full and o_overflow reflect registered state and update on the edge that changes count or the drop flag.
- Latency from an empty, idle buffer:
  - Push sampled at edge n.
  - FSM enters LOAD at edge n+1.
  - o_led and o_showing become valid after edge n+2.
  - Display holds for exactly HOLD_CYCLES cycles, then GAP_CYCLES blank cycles.
- Back-to-back entries: one LOAD cycle between consecutive SHOW periods, with o_led=0 and o_showing=0 during LOAD.
- Entry period is therefore 1+HOLD_CYCLES+GAP_CYCLES cycles.

## Configuration
- LED_TRACE_SKIP_X0_EN:
  - Defined: pushes with i_wb_rd==0 are ignored. They do not store and do not set overflow.
  - Undefined: every i_wb_valid push is recorded, including writes to x0.

## Structure
- Package led_trace_pkg holds:
  - typedef enum for the state (IDLE, LOAD, SHOW, GAP);
  - typedef struct packed trace_entry_t {rd[4:0], data[7:0]};
  - localparam for the default HOLD_CYCLES.
- Sub-module trace_fifo holds the storage array, pointers, count, full/empty and the drop detection.
- led_trace_player holds the FSM, hold/gap counter, display registers and byte selection.

## Test plan
- Reset only: all outputs at reset values, o_empty=1, o_led=0 for 20 cycles.
- Single push (defaults), rd=5, data=0x1234_56AB, byte_sel=0, at edge n: LOAD at n+1; o_led=0xAB, o_led_rd=5, o_showing=1 for edges n+2..n+5; o_led=0 for 1 gap cycle; then IDLE with o_empty=1.
- Overflow: 10 consecutive pushes with data low bytes 0x01..0x0A and the FSM not yet popping:
  - o_full=1 after 8 pushes;
  - a push at count==8 is dropped and sets o_overflow=1;
  - displayed sequence is 0x01, 0x02, …, 0x08 only, and o_overflow stays 1.
- Wrap and concurrency: 20 pushes spaced 3 cycles apart with byte_sel cycling 0..3.
  - Displayed bytes match a scoreboard in order.
  - Pointers wrap correctly; no drops.
- Reset mid-SHOW: assert reset for 1 cycle during a SHOW of 0x55 with 3 entries buffered.
  - o_led=0 immediately and o_empty=1.
  - No further display after release.
- LED_TRACE_SKIP_X0_EN: pushes with rd=0 then rd=3 (data 0xFF, 0x33).
  - Defined: only 0x33 is shown.
  - Undefined: 0xFF then 0x33 are shown.
